// File: rtl/fp_addsub_control.sv
// Sequencing FSM for the floating-point add/sub datapath: load, align, add,
// normalize, round, optional renormalize, then a one-cycle done pulse.
module fp_addsub_control #(
  parameter int MANT_W    = 23,
  parameter int SHIFT_SAT = MANT_W + 3,
  parameter int MAX_NORM  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_sub,
  input  logic [7:0] expDiff,
  input  logic       carry,
  input  logic       lead_one,
  input  logic       is_zero,
  input  logic       round_carry,
  output logic       smallerExpSrc,
  output logic [7:0] shiftRightQtt,
  output logic [1:0] operation,
  output logic       normalization_src,
  output logic       shift_src,
  output logic       load_operands,
  output logic       load_align,
  output logic       load_alu,
  output logic       load_norm,
  output logic       load_round,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    RENORM = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t     state, state_nxt;
  logic       op_q;
  logic [4:0] norm_cnt, norm_cnt_nxt;
  logic [7:0] exp_mag;

  // Magnitude of the signed exponent difference; 8'h80 maps to 128 and saturates.
  assign exp_mag = expDiff[7] ? (~expDiff + 8'd1) : expDiff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= 1'b0;
      norm_cnt <= 5'd0;
    end else begin
      state    <= state_nxt;
      norm_cnt <= norm_cnt_nxt;
      if (state == IDLE && start) op_q <= op_sub;
    end
  end

  always_comb begin
    state_nxt         = state;
    norm_cnt_nxt      = norm_cnt;
    smallerExpSrc     = 1'b0;
    shiftRightQtt     = 8'd0;
    normalization_src = 1'b0;
    shift_src         = 1'b0;
    load_operands     = 1'b0;
    load_align        = 1'b0;
    load_alu          = 1'b0;
    load_norm         = 1'b0;
    load_round        = 1'b0;
    done              = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        load_operands = 1'b1;
        norm_cnt_nxt  = 5'd0;
        state_nxt     = ALIGN;
      end
      ALIGN: begin
        load_align    = 1'b1;
        smallerExpSrc = ~expDiff[7];
        shiftRightQtt = (exp_mag > 8'(SHIFT_SAT)) ? 8'(SHIFT_SAT) : exp_mag;
        state_nxt     = ADD;
      end
      ADD: begin
        load_alu  = 1'b1;
        state_nxt = NORM;
      end
      NORM: begin
        // Mealy decision: overflow wins, then "already normalized/zero/limit".
        if (carry) begin
          shift_src     = 1'b1;
          shiftRightQtt = 8'd1;
          load_norm     = 1'b1;
          state_nxt     = ROUND;
        end else if (lead_one || is_zero || norm_cnt == 5'(MAX_NORM)) begin
          state_nxt = ROUND;
        end else begin
          shiftRightQtt = 8'd1;
          load_norm     = 1'b1;
          norm_cnt_nxt  = norm_cnt + 5'd1;
        end
      end
      ROUND: begin
        load_round = 1'b1;
        state_nxt  = round_carry ? RENORM : DONE;
      end
      RENORM: begin
        // Always exits to DONE, so ROUND cannot loop back here twice.
        normalization_src = 1'b1;
        shift_src         = 1'b1;
        shiftRightQtt     = 8'd1;
        load_norm         = 1'b1;
        state_nxt         = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign operation = (state == IDLE) ? 2'b00 : {1'b0, op_q};
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_addsub_control.sv
// Self-checking bench for fp_addsub_control: a behavioural datapath driver plus
// a per-cycle expected-output trace built from the operation's parameters.
module tb_fp_addsub_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, op_sub, carry, lead_one, is_zero, round_carry;
  logic [7:0] expDiff;
  logic       smallerExpSrc, normalization_src, shift_src;
  logic [7:0] shiftRightQtt;
  logic [1:0] operation;
  logic       load_operands, load_align, load_alu, load_norm, load_round;
  logic       busy, done;
  logic [2:0] dbg_state;

  typedef struct packed {
    logic       sm;
    logic [7:0] qtt;
    logic [1:0] op;
    logic       nsrc;
    logic       ssrc;
    logic       lo, la, lalu, ln, lr;
    logic       busy;
    logic       done;
  } out_t;

  out_t        got_v;
  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          shifts_seen;

  fp_addsub_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .expDiff(expDiff),
    .carry(carry), .lead_one(lead_one), .is_zero(is_zero), .round_carry(round_carry),
    .smallerExpSrc(smallerExpSrc), .shiftRightQtt(shiftRightQtt), .operation(operation),
    .normalization_src(normalization_src), .shift_src(shift_src),
    .load_operands(load_operands), .load_align(load_align), .load_alu(load_alu),
    .load_norm(load_norm), .load_round(load_round), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  assign got_v = {smallerExpSrc, shiftRightQtt, operation, normalization_src, shift_src,
                  load_operands, load_align, load_alu, load_norm, load_round, busy, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic out_t busy_v(input logic o);
    out_t v = '0;
    v.busy = 1'b1;
    v.op   = {1'b0, o};
    return v;
  endfunction

  task automatic push(input string tag, input out_t v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // One operation: o=op_sub, d=expDiff, c=carry, z=is_zero, k=left shifts
  // before lead_one appears, never=lead_one stays 0, rc=round_carry,
  // keep=start stays high afterwards. Called just after a rising edge in IDLE.
  task automatic run_op(input logic o, input logic [7:0] d, input logic c, input logic z,
                        input int k, input logic never, input logic rc, input logic keep);
    out_t v;
    int   mag, n_left, n;
    logic pulse;
    op_sub = o; expDiff = d; carry = c; is_zero = z; round_carry = rc;
    shifts_seen = 0;
    lead_one = !never && (k == 0);
    start = 1'b1;

    push("idle", '0);
    v = busy_v(o); v.lo = 1'b1; push("load", v);
    mag = ($signed(d) < 0) ? -int'($signed(d)) : int'($signed(d));
    v = busy_v(o); v.la = 1'b1; v.sm = ($signed(d) >= 0);
    v.qtt = 8'((mag > 26) ? 26 : mag);
    push("align", v);
    v = busy_v(o); v.lalu = 1'b1; push("add", v);
    if (c) begin
      v = busy_v(o); v.ssrc = 1'b1; v.qtt = 8'd1; v.ln = 1'b1; push("norm_right", v);
    end else if (z) begin
      push("norm_zero", busy_v(o));
    end else begin
      n_left = never ? 25 : k;
      for (int i = 0; i < n_left; i++) begin
        v = busy_v(o); v.qtt = 8'd1; v.ln = 1'b1; push("norm_left", v);
      end
      push("norm_exit", busy_v(o));
    end
    v = busy_v(o); v.lr = 1'b1; push("round", v);
    if (rc) begin
      v = busy_v(o); v.nsrc = 1'b1; v.ssrc = 1'b1; v.qtt = 8'd1; v.ln = 1'b1;
      push("renorm", v);
    end
    v = busy_v(o); v.done = 1'b1; push("done", v);

    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag_q.pop_front(), 32'(got_v), 32'(exp_q.pop_front()));
      pulse = load_norm && !shift_src && !normalization_src;
      @(posedge clk);
      #1;
      if (i == 0) start = keep;
      // Datapath model: a committed left shift moves the mantissa one bit up.
      if (pulse) shifts_seen++;
      lead_one = !never && (shifts_seen >= k);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; expDiff = 8'd0;
    carry = 1'b0; lead_one = 1'b0; is_zero = 1'b0; round_carry = 1'b0;

    // Reset / idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(got_v), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_outputs", 32'(got_v), 32'd0);

    // Async reset while in ADD
    start = 1'b1; op_sub = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_alu", 32'(load_alu), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(got_v), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    run_op(1'b0, 8'd3,   1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);  // base add
    run_op(1'b0, 8'hFB,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);  // negative diff
    run_op(1'b0, 8'd40,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);  // saturate
    run_op(1'b1, 8'h80,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);  // most negative
    run_op(1'b0, 8'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0);  // equal exponents
    run_op(1'b1, 8'd1,   1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0);  // cancellation
    run_op(1'b0, 8'd2,   1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0);  // carry + renorm
    run_op(1'b1, 8'd5,   1'b0, 1'b1, 4,  1'b0, 1'b0, 1'b0);  // zero result
    run_op(1'b1, 8'hF0,  1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b0);  // shift limit
    run_op(1'b0, 8'd26,  1'b0, 1'b0, 25, 1'b0, 1'b1, 1'b0);  // 25 shifts, renorm
    run_op(1'b0, 8'd7,   1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1);  // start held high
    run_op(1'b1, 8'hE6,  1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b1);
    run_op(1'b0, 8'd27,  1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0);
    start = 1'b0;

    // Randomized operations
    for (int t = 0; t < 30; t++) begin
      run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
             int'($urandom_range(0, 25)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    @(negedge clk);
    check("final_idle", 32'(got_v), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_control.md
Name: fp_addsub_control

Overview:
- Multi-cycle control FSM that drives the control inputs of the floatingOperation add/sub datapath.
- Accepts a start request and sequences the stages: operand load, exponent alignment, mantissa add/sub, normalization (iterative left shift or single right shift), rounding, one optional post-round renormalization.
- Consumes datapath status flags and produces datapath select/load strobes plus a start/done/busy handshake toward the issuing core.

Parameters:
- MANT_W, 23, stored mantissa width (single precision).
- SHIFT_SAT, 26, alignment shift saturation value (MANT_W+3; larger shifts discard all bits anyway).
- MAX_NORM, 25, maximum left-normalization shifts before the result is treated as zero.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = add, 1 = sub; captured when start is accepted.
- expDiff  input  8  two's-complement expA − expB from the datapath.
- carry  input  1  ALU mantissa overflow (bit above hidden bit set).
- lead_one  input  1  hidden-bit position of the normalization register is 1.
- is_zero  input  1  ALU/normalization mantissa is all zero.
- round_carry  input  1  rounding overflowed into bit MANT_W+1.
- smallerExpSrc  output  1  0 = A has the smaller exponent, 1 = B does.
- shiftRightQtt  output  8  shift amount for the datapath shifter.
- operation  output  2  00 add, 01 sub (10 reserved, never driven).
- normalization_src  output  1  0 = ALU result, 1 = rounded result.
- shift_src  output  1  0 = left, 1 = right.
- load_operands, load_align, load_alu, load_norm, load_round  output  1 each  datapath register enables.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, LOAD, ALIGN, ADD, NORM, ROUND, RENORM, DONE. The state register is the only flop besides op_q (captured op) and norm_cnt (5 bits).
- Reset (async, rst_n=0): state=IDLE, op_q=0, norm_cnt=0. All outputs 0, including operation=00. This applies at any point, including mid-operation; no partial done is issued.
- IDLE: if start=1, go to LOAD and set op_q=op_sub. Otherwise stay. start is ignored in every other state.
- LOAD (1 cycle): load_operands=1, norm_cnt cleared. Next state ALIGN.
- ALIGN (1 cycle): load_align=1.
  - smallerExpSrc = 1 if expDiff ≥ 0 (signed; covers equality), else 0.
  - shiftRightQtt = |expDiff| saturated to SHIFT_SAT; expDiff=8'h80 gives SHIFT_SAT.
  - Next state ADD.
- ADD (1 cycle): load_alu=1. Next state NORM.
- operation: {1'b0, op_q} in every state except IDLE, which drives 00.
- NORM: decisions are Mealy on the current inputs, evaluated in priority order:
  - carry=1: shift_src=1, shiftRightQtt=1, load_norm=1, next state ROUND.
  - Else lead_one=1 or is_zero=1 or norm_cnt==MAX_NORM: load_norm=0, next state ROUND.
  - Else: shift_src=0, shiftRightQtt=1, load_norm=1, norm_cnt+1, stay in NORM.
  - normalization_src=0 throughout NORM.
- ROUND (1 cycle): load_round=1.
  - round_carry=1 and not yet renormalized: next state RENORM.
  - Otherwise: next state DONE.
- RENORM (1 cycle): normalization_src=1, shift_src=1, shiftRightQtt=1, load_norm=1. Next state DONE. At most one RENORM per operation.
- DONE (1 cycle): done=1. Next state IDLE. A new start is accepted on the next IDLE cycle.
- Default values of any output not named for a state: 0.
- Latency, counted from the edge that samples start=1 as E0:
  - Base case: done is high in the cycle following E5.
  - Add k cycles for k left shifts, and 1 more if RENORM is taken.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1 → all outputs 0, busy=0. Pulse start with no datapath activity; assert rst_n=0 while in ADD → state IDLE immediately (asynchronously), operation=00, no done pulse.
- Add, expA=121, expB=118: start=1, op_sub=0, expDiff=8'd3, carry=0, lead_one=1 → in ALIGN, smallerExpSrc=1, shiftRightQtt=3. done pulses exactly in the cycle after E5. operation=00 throughout busy.
- Negative and saturated alignment:
  - expDiff=8'hFB (−5) → smallerExpSrc=0, shiftRightQtt=5.
  - expDiff=8'd40 → shiftRightQtt=26.
  - expDiff=8'h80 → shiftRightQtt=26.
- Sub with cancellation: op_sub=1, carry=0, lead_one held 0 for the first 3 NORM cycles then 1 → operation=01. Three load_norm pulses with shift_src=0, shiftRightQtt=1. done arrives 3 cycles later than the base case.
- Carry then round overflow: in NORM, carry=1 → one load_norm with shift_src=1. In ROUND, round_carry=1 → RENORM cycle with normalization_src=1, shift_src=1. done arrives 1 cycle later than the base case; RENORM is never entered twice.
- Zero/limit handling:
  - is_zero=1 in NORM → no load_norm, go straight to ROUND.
  - lead_one=0 and is_zero=0 held forever → exactly 25 left shifts, then ROUND, then done.
  - start held high continuously → a new operation begins only on the IDLE cycle after each done.
